// File: rtl/light_gate_ctrl.sv
// Debounced multi-channel light controller: switch pairs gated by a shared enable drive
// per-channel lights in either level-with-hold or toggle mode.
module light_gate_ctrl #(
    parameter int N           = 4,
    parameter int DB_CYCLES   = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c,
    input  logic         mode,
    output logic [N-1:0] f,
    output logic [N-1:0] f_rise
);
    localparam int NI  = 2 * N + 1;
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_ON   = 2'd1,
        S_HOLD = 2'd2
    } chan_state_e;

    logic [NI-1:0] raw_w;
    logic [NI-1:0] sync1_q;
    logic [NI-1:0] sync2_q;
    logic [NI-1:0] db_w;
    logic [N-1:0]  r_w;
    logic [N-1:0]  r_q;
    logic [N-1:0]  on_w;
    logic [N-1:0]  f_q;
    logic [N-1:0]  f_rise_q;
    logic          mode_q;
    logic          mode_chg_w;

    // Bit layout: [N-1:0] = a, [2N-1:N] = b, [2N] = c.
    assign raw_w = {c, b, a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_w;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_db
            logic [DBW-1:0] cnt_q;
            logic [DBW-1:0] cnt_d;
            logic           db_q;
            logic           db_d;

            // Counter only runs while the synced input disagrees; it tops out at DB_CYCLES-1.
            always_comb begin
                cnt_d = '0;
                db_d  = db_q;
                if (sync2_q[gi] != db_q) begin
                    if (cnt_q == DB_LAST) begin
                        db_d = ~db_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    db_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    db_q  <= db_d;
                end
            end

            assign db_w[gi] = db_q;
        end
    endgenerate

    assign r_w        = {N{db_w[2*N]}} & (db_w[N-1:0] | db_w[2*N-1:N]);
    assign mode_chg_w = mode ^ mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            r_q    <= '0;
        end else begin
            mode_q <= mode;
            r_q    <= mode_chg_w ? '0 : r_w;
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            chan_state_e   state_q;
            chan_state_e   state_d;
            logic [HW-1:0] hold_q;
            logic [HW-1:0] hold_d;

            always_comb begin
                state_d = state_q;
                hold_d  = hold_q;
                if (mode_chg_w) begin
                    state_d = S_OFF;
                    hold_d  = '0;
                end else if (mode_q) begin
                    if (r_w[gi] && !r_q[gi]) begin
                        state_d = (state_q == S_OFF) ? S_ON : S_OFF;
                    end
                end else begin
                    case (state_q)
                        S_OFF: begin
                            if (r_w[gi]) begin
                                state_d = S_ON;
                            end
                        end
                        S_ON: begin
                            if (!r_w[gi]) begin
                                state_d = S_HOLD;
                                hold_d  = HOLD_LOAD;
                            end
                        end
                        S_HOLD: begin
                            if (r_w[gi]) begin
                                state_d = S_ON;
                            end else if (hold_q == '0) begin
                                state_d = S_OFF;
                            end else begin
                                hold_d = hold_q - 1'b1;
                            end
                        end
                        default: begin
                            state_d = S_OFF;
                            hold_d  = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_OFF;
                    hold_q  <= '0;
                end else begin
                    state_q <= state_d;
                    hold_q  <= hold_d;
                end
            end

            assign on_w[gi] = (state_q != S_OFF);
        end
    endgenerate

    // The output stage adds the final pipeline edge; a mode change blanks it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q      <= '0;
            f_rise_q <= '0;
        end else if (mode_chg_w) begin
            f_q      <= '0;
            f_rise_q <= '0;
        end else begin
            f_q      <= on_w;
            f_rise_q <= on_w & ~f_q;
        end
    end

    assign f      = f_q;
    assign f_rise = f_rise_q;

endmodule

// File: tb/tb_light_gate_ctrl.sv
// Bench for light_gate_ctrl: directed scenarios plus randomized switching, checked every
// cycle against a behavioural model built from the debounce/hold/toggle rules.
module tb_light_gate_ctrl;
    localparam int N  = 4;
    localparam int DB = 8;
    localparam int H  = 16;
    localparam int NI = 2 * N + 1;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    logic         mode;
    logic [N-1:0] f;
    logic [N-1:0] f_rise;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rise3 = 0;

    light_gate_ctrl #(
        .N          (N),
        .DB_CYCLES  (DB),
        .HOLD_CYCLES(H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .mode  (mode),
        .f     (f),
        .f_rise(f_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    logic [NI-1:0] m_s1   = '0;
    logic [NI-1:0] m_s2   = '0;
    logic [NI-1:0] m_db   = '0;
    logic [DB-1:0] m_hist [NI];
    logic [N-1:0]  m_on   = '0;
    logic [N-1:0]  m_rprev = '0;
    logic [N-1:0]  exp_f  = '0;
    logic [N-1:0]  exp_rise = '0;
    logic [N-1:0]  r_now;
    logic [N-1:0]  new_f;
    logic          m_mode = 1'b0;
    logic          mc;
    logic          all_diff;
    int            last_hi [N];
    int            k = 0;

    initial begin
        for (int i = 0; i < NI; i++) m_hist[i] = '0;
        for (int ch = 0; ch < N; ch++) last_hi[ch] = -1000;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = '0; m_s2 = '0; m_db = '0;
                for (int i = 0; i < NI; i++) m_hist[i] = '0;
                for (int ch = 0; ch < N; ch++) last_hi[ch] = -1000;
                m_on = '0; m_rprev = '0; m_mode = 1'b0;
                exp_f = '0; exp_rise = '0; k = 0;
            end else begin
                k++;
                // request as seen before this edge
                r_now = {N{m_db[2*N]}} & (m_db[N-1:0] | m_db[2*N-1:N]);
                // debounced value flips once the last DB synced samples all disagree with it
                for (int i = 0; i < NI; i++) begin
                    m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
                    all_diff = 1'b1;
                    for (int d = 0; d < DB; d++) if (m_hist[i][d] == m_db[i]) all_diff = 1'b0;
                    if (all_diff) m_db[i] = ~m_db[i];
                end
                m_s2 = m_s1;
                m_s1 = {c, b, a};
                mc = (mode != m_mode);
                new_f = mc ? '0 : m_on;
                exp_rise = new_f & ~exp_f;
                exp_f = new_f;
                for (int ch = 0; ch < N; ch++) begin
                    if (mc) begin
                        m_on[ch] = 1'b0;
                        last_hi[ch] = -1000;
                    end else if (!m_mode) begin
                        // level mode: lit while the request was seen high within the last H+1 samples
                        if (r_now[ch]) last_hi[ch] = k - 1;
                        m_on[ch] = (last_hi[ch] >= k - 1 - H);
                    end else if (r_now[ch] && !m_rprev[ch]) begin
                        m_on[ch] = ~m_on[ch];
                    end
                end
                m_rprev = mc ? '0 : r_now;
                m_mode = mode;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            tests++;
            if (f !== exp_f) begin
                fails++;
                $display("FAIL model_f cyc=%0d: got %b expected %b", cyc, f, exp_f);
            end
            tests++;
            if (f_rise !== exp_rise) begin
                fails++;
                $display("FAIL model_f_rise cyc=%0d: got %b expected %b", cyc, f_rise, exp_rise);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp_v);
        end else begin
            $display("[TB] check %s cyc=%0d ok value %0h", name, cyc, act);
        end
    endtask

    // advance to the negedge following rising edge number 'target', counting f_rise[3] pulses
    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            if (f_rise[3]) rise3++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    int t, t2, e;
    int ok;

    initial begin
        a = '0; b = '0; c = 1'b0; mode = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        ok = 1;
        repeat (50) begin
            @(negedge clk);
            if (f !== '0 || f_rise !== '0) ok = 0;
        end
        chk("idle_quiet", ok, 1);

        c = 1'b1;
        step_to(cyc + 20);

        // single press latency
        t = cyc + 1; a[0] = 1'b1;
        step_to(t + 10); chk("a0_lat_pre", f, 0);
        step_to(t + 11); chk("a0_lat_f", f, 4'b0001); chk("a0_lat_rise", f_rise, 4'b0001);
        chk("model_pin_a0", exp_f, 4'b0001);
        step_to(t + 12); chk("a0_rise_clr", f_rise, 0); chk("a0_still_on", f, 4'b0001);
        a[0] = 1'b0;
        step_to(cyc + 40);
        chk("a0_off", f, 0);

        // short bounce rejected, long press accepted
        t = cyc + 1; b[2] = 1'b1;
        step_to(t + 4); b[2] = 1'b0;
        ok = 1;
        repeat (25) begin
            @(negedge clk);
            if (f[2] !== 1'b0) ok = 0;
        end
        chk("b2_short_reject", ok, 1);
        t = cyc + 1; b[2] = 1'b1;
        step_to(t + 10); chk("b2_long_pre", f[2], 0);
        step_to(t + 11); chk("b2_long_on", f[2], 1);
        b[2] = 1'b0;
        step_to(cyc + 40);

        // hold extension
        t = cyc + 1; a[1] = 1'b1;
        step_to(t + 14); chk("a1_on", f[1], 1);
        t2 = cyc + 1; a[1] = 1'b0;
        ok = 1;
        while (cyc < t2 + 26) begin
            @(negedge clk);
            if (f[1] !== 1'b1) ok = 0;
        end
        chk("hold_stays_on", ok, 1);
        chk("model_pin_hold", exp_f[1], 1);
        step_to(t2 + 27); chk("hold_off", f[1], 0);
        step_to(cyc + 10);

        // re-press during hold: continuous on, no new pulse
        t = cyc + 1; a[1] = 1'b1;
        step_to(t + 14);
        t2 = cyc + 1; a[1] = 1'b0;
        step_to(t2 + 9); a[1] = 1'b1;
        ok = 1; rise3 = 0;
        e = 0;
        while (cyc < t2 + 50) begin
            @(negedge clk);
            if (f[1] !== 1'b1) ok = 0;
            if (f_rise[1]) e++;
        end
        chk("repress_on", ok, 1);
        chk("repress_norise", e, 0);
        a[1] = 1'b0;
        step_to(cyc + 50);

        // toggle mode
        mode = 1'b1;
        step_to(cyc + 5);
        rise3 = 0;
        t = cyc + 1; a[3] = 1'b1;
        step_to(t + 11); chk("tog_on", f[3], 1);
        step_to(t + 14);
        a[3] = 1'b0;
        step_to(cyc + 14); chk("tog_release_keeps", f[3], 1);
        t = cyc + 1; a[3] = 1'b1;
        step_to(t + 11); chk("tog_off", f[3], 0);
        chk("tog_one_rise", rise3, 1);
        a[3] = 1'b0;
        step_to(cyc + 14);
        t = cyc + 1; a[3] = 1'b1;
        step_to(t + 11); chk("tog_on_again", f[3], 1);
        mode = 1'b0; e = cyc + 1;
        step_to(e); chk("mode_flip_off", f, 0); chk("mode_flip_norise", f_rise, 0);
        a[3] = 1'b0;
        step_to(cyc + 45);

        // asynchronous reset mid-hold
        t = cyc + 1; a[0] = 1'b1;
        step_to(t + 14);
        t2 = cyc + 1; a[0] = 1'b0;
        step_to(t2 + 15); chk("pre_rst_hold", f[0], 1);
        @(posedge clk);
        #2 rst_n = 1'b0; a[0] = 1'b1;
        #1 chk("async_rst_f", f, 0); chk("async_rst_rise", f_rise, 0);
        #1 rst_n = 1'b1;
        t = cyc + 1;
        ok = 1;
        while (cyc < t + 10) begin
            @(negedge clk);
            if (f[0] !== 1'b0) ok = 0;
        end
        chk("post_rst_stays_off", ok, 1);
        step_to(t + 11); chk("post_rst_requal", f[0], 1);
        a[0] = 1'b0;
        step_to(cyc + 40);

        // randomized switching
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) a[i] = ~a[i];
                if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
            end
            if ($urandom_range(0, 39) == 0) c = ~c;
            if ($urandom_range(0, 249) == 0) mode = ~mode;
            if (n == 1500) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        step_to(cyc + 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
